// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite subordinate terminating the link in NumRegs byte-strobed registers.
// Optional `AXI_LITE_REG_SLAVE_PROT_EN: unprivileged (prot[0]==0) accesses get SLVERR.
module axi_lite_reg_slave #(
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          NumRegs    = 16,
    parameter logic [DataWidth-1:0] ResetValue = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [AddrWidth-1:0]           aw_addr_i,
    input  logic [2:0]                     aw_prot_i,
    input  logic                           aw_valid_i,
    output logic                           aw_ready_o,
    input  logic [DataWidth-1:0]           w_data_i,
    input  logic [DataWidth/8-1:0]         w_strb_i,
    input  logic                           w_valid_i,
    output logic                           w_ready_o,
    output logic [1:0]                     b_resp_o,
    output logic                           b_valid_o,
    input  logic                           b_ready_i,
    input  logic [AddrWidth-1:0]           ar_addr_i,
    input  logic [2:0]                     ar_prot_i,
    input  logic                           ar_valid_i,
    output logic                           ar_ready_o,
    output logic [DataWidth-1:0]           r_data_o,
    output logic [1:0]                     r_resp_o,
    output logic                           r_valid_o,
    input  logic                           r_ready_i,
    output logic [NumRegs*DataWidth-1:0]   regs_o
);

    localparam int unsigned          StrbWidth  = DataWidth / 8;
    localparam int unsigned          Offs       = $clog2(StrbWidth);
    localparam int unsigned          IdxWidth   = $clog2(NumRegs);
    localparam logic [AddrWidth-1:0] AddrLimit  = AddrWidth'(NumRegs * StrbWidth);
    localparam logic [1:0]           RespOkay   = 2'b00;
    localparam logic [1:0]           RespSlvErr = 2'b10;

    logic                                r_aw_full;
    logic [AddrWidth-1:0]                r_aw_addr;
    logic [2:0]                          r_aw_prot;
    logic                                r_w_full;
    logic [DataWidth-1:0]                r_w_data;
    logic [StrbWidth-1:0]                r_w_strb;
    logic                                r_b_valid;
    logic [1:0]                          r_b_resp;
    logic                                r_r_valid;
    logic [DataWidth-1:0]                r_r_data;
    logic [1:0]                          r_r_resp;
    logic [NumRegs-1:0][DataWidth-1:0]   r_regs;

    logic                                w_aw_hs;
    logic                                w_w_hs;
    logic                                w_ar_hs;
    logic                                w_commit;
    logic                                w_wr_ok;
    logic                                w_rd_ok;
    logic [IdxWidth-1:0]                 w_wr_idx;
    logic [IdxWidth-1:0]                 w_rd_idx;

    // Readies depend only on local state, never on the incoming valids.
    assign aw_ready_o = !r_aw_full;
    assign w_ready_o  = !r_w_full;
    assign ar_ready_o = !r_r_valid;

    assign w_aw_hs  = aw_valid_i && !r_aw_full;
    assign w_w_hs   = w_valid_i && !r_w_full;
    assign w_ar_hs  = ar_valid_i && !r_r_valid;
    assign w_commit = r_aw_full && r_w_full && !r_b_valid;

    assign w_wr_idx = r_aw_addr[Offs +: IdxWidth];
    assign w_rd_idx = ar_addr_i[Offs +: IdxWidth];

`ifdef AXI_LITE_REG_SLAVE_PROT_EN
    logic w_unused_prot;
    assign w_unused_prot = ^{r_aw_prot[2:1], ar_prot_i[2:1]};
    assign w_wr_ok = (r_aw_addr < AddrLimit) && r_aw_prot[0];
    assign w_rd_ok = (ar_addr_i < AddrLimit) && ar_prot_i[0];
`else
    logic w_unused_prot;
    assign w_unused_prot = ^{r_aw_prot, ar_prot_i};
    assign w_wr_ok = (r_aw_addr < AddrLimit);
    assign w_rd_ok = (ar_addr_i < AddrLimit);
`endif

    // AW and W are captured independently; both drain together on commit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_aw_prot <= '0;
        end else if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_addr <= aw_addr_i;
            r_aw_prot <= aw_prot_i;
        end else if (w_commit) begin
            r_aw_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_w_full <= 1'b0;
            r_w_data <= '0;
            r_w_strb <= '0;
        end else if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_w_data <= w_data_i;
            r_w_strb <= w_strb_i;
        end else if (w_commit) begin
            r_w_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_b_valid <= 1'b0;
            r_b_resp  <= RespOkay;
        end else if (w_commit) begin
            r_b_valid <= 1'b1;
            r_b_resp  <= w_wr_ok ? RespOkay : RespSlvErr;
        end else if (r_b_valid && b_ready_i) begin
            r_b_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_regs <= {NumRegs{ResetValue}};
        end else if (w_commit && w_wr_ok) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
                if (r_w_strb[b]) r_regs[w_wr_idx][b*8 +: 8] <= r_w_data[b*8 +: 8];
            end
        end
    end

    // Read samples r_regs before any same-edge commit lands, so it sees the old value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
            r_r_resp  <= RespOkay;
        end else if (w_ar_hs) begin
            r_r_valid <= 1'b1;
            r_r_data  <= w_rd_ok ? r_regs[w_rd_idx] : '0;
            r_r_resp  <= w_rd_ok ? RespOkay : RespSlvErr;
        end else if (r_r_valid && r_ready_i) begin
            r_r_valid <= 1'b0;
        end
    end

    assign b_valid_o = r_b_valid;
    assign b_resp_o  = r_b_resp;
    assign r_valid_o = r_r_valid;
    assign r_data_o  = r_r_data;
    assign r_resp_o  = r_r_resp;
    assign regs_o    = r_regs;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized + directed bench for axi_lite_reg_slave against an array-based register model.
// Honours `AXI_LITE_REG_SLAVE_PROT_EN when the build defines it.
module tb_axi_lite_reg_slave;

    localparam int NREGS = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [31:0]   aw_addr_i;
    logic [2:0]    aw_prot_i;
    logic          aw_valid_i;
    logic          aw_ready_o;
    logic [31:0]   w_data_i;
    logic [3:0]    w_strb_i;
    logic          w_valid_i;
    logic          w_ready_o;
    logic [1:0]    b_resp_o;
    logic          b_valid_o;
    logic          b_ready_i;
    logic [31:0]   ar_addr_i;
    logic [2:0]    ar_prot_i;
    logic          ar_valid_i;
    logic          ar_ready_o;
    logic [31:0]   r_data_o;
    logic [1:0]    r_resp_o;
    logic          r_valid_o;
    logic          r_ready_i;
    logic [NREGS*32-1:0] regs_o;

    axi_lite_reg_slave #(
        .AddrWidth(32), .DataWidth(32), .NumRegs(NREGS), .ResetValue(32'h0)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_addr_i(aw_addr_i), .aw_prot_i(aw_prot_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .ar_addr_i(ar_addr_i), .ar_prot_i(ar_prot_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .regs_o(regs_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] mdl [NREGS];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit prot_ok(input logic [2:0] prot);
`ifdef AXI_LITE_REG_SLAVE_PROT_EN
        return prot[0];
`else
        return 1'b1;
`endif
    endfunction

    // Model: 16 words, byte address / 4 selects the word, anything >= 64 is an error.
    task automatic mdl_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [2:0] prot, output logic [1:0] resp);
        if (addr < 32'd64 && prot_ok(prot)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[int'(addr) / 4][b*8 +: 8] = data[b*8 +: 8];
            resp = 2'b00;
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic mdl_rd(input logic [31:0] addr, input logic [2:0] prot,
                          output logic [31:0] data, output logic [1:0] resp);
        if (addr < 32'd64 && prot_ok(prot)) begin
            data = mdl[int'(addr) / 4];
            resp = 2'b00;
        end else begin
            data = 32'h0;
            resp = 2'b10;
        end
    endtask

    // Presents AW after aw_dly cycles and W after w_dly cycles; returns B resp.
    // B must appear exactly one edge after the later handshake edge (cycle N -> N+2).
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [2:0] prot, input int aw_dly, input int w_dly,
                             output logic [1:0] resp);
        int  t = 0;
        int  lat = 0;
        bit  aw_done = 0, w_done = 0, aw_hs, w_hs;
        aw_addr_i = addr; aw_prot_i = prot; w_data_i = data; w_strb_i = strb;
        while (!(aw_done && w_done) && t < 50) begin
            aw_valid_i = !aw_done && t >= aw_dly;
            w_valid_i  = !w_done && t >= w_dly;
            aw_hs = aw_valid_i && aw_ready_o;
            w_hs  = w_valid_i && w_ready_o;
            tick();
            t++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
        end
        aw_valid_i = 0; w_valid_i = 0;
        if (t >= 50) chk("aw_w_accept_timeout", 0, 1);
        while (!b_valid_o && lat < 50) begin
            tick();
            lat++;
        end
        chk("b_latency", 64'(lat), 64'd1);
        resp = b_resp_o;
        tick();
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [2:0] prot,
                            output logic [31:0] data, output logic [1:0] resp);
        int t = 0;
        ar_addr_i = addr; ar_prot_i = prot; ar_valid_i = 1;
        while (!ar_ready_o && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) chk("ar_accept_timeout", 0, 1);
        tick();
        ar_valid_i = 0;
        chk("r_latency", 64'(r_valid_o), 64'd1);
        data = r_data_o;
        resp = r_resp_o;
        tick();
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NREGS; i++)
            chk(tag, regs_o[i*32 +: 32], mdl[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, ed, addr, data;
        logic [1:0]  rr, er;
        logic [3:0]  strb;
        logic [2:0]  prot;

        rst_ni = 0;
        aw_addr_i = 0; aw_prot_i = 0; aw_valid_i = 0;
        w_data_i = 0; w_strb_i = 0; w_valid_i = 0;
        ar_addr_i = 0; ar_prot_i = 0; ar_valid_i = 0;
        b_ready_i = 1; r_ready_i = 1;
        for (int i = 0; i < NREGS; i++) mdl[i] = 32'h0;

        repeat (3) tick();
        chk("rst_b_valid", b_valid_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_r_data", r_data_o, 0);
        chk("rst_regs", regs_o, '0);
        rst_ni = 1;
        tick();
        chk("rst_ar_ready", ar_ready_o, 1);
        chk("rst_aw_ready", aw_ready_o, 1);
        chk("rst_w_ready", w_ready_o, 1);

        axi_read(32'h0C, 3'b001, rd, rr);
        chk("rd_reset_data", rd, 32'h0);
        chk("rd_reset_resp", rr, 2'b00);

        // W leads AW by two cycles.
        axi_write(32'h08, 32'hDEADBEEF, 4'hF, 3'b001, 2, 0, rr);
        mdl_wr(32'h08, 32'hDEADBEEF, 4'hF, 3'b001, er);
        chk("w_first_resp", rr, 2'b00);
        chk("w_first_regs_o", regs_o[95:64], 32'hDEADBEEF);
        axi_read(32'h08, 3'b001, rd, rr);
        chk("w_first_read", rd, 32'hDEADBEEF);

        axi_write(32'h04, 32'h11223344, 4'hF, 3'b001, 0, 0, rr);
        mdl_wr(32'h04, 32'h11223344, 4'hF, 3'b001, er);
        axi_write(32'h04, 32'hAABBCCDD, 4'b0101, 3'b001, 1, 0, rr);
        mdl_wr(32'h04, 32'hAABBCCDD, 4'b0101, 3'b001, er);
        axi_read(32'h04, 3'b001, rd, rr);
        chk("partial_read", rd, 32'h11BB33DD);

        axi_write(32'h14, 32'hFFFFFFFF, 4'h0, 3'b001, 0, 0, rr);
        chk("zero_strb_resp", rr, 2'b00);
        chk("zero_strb_reg5", regs_o[191:160], 32'h0);

        axi_write(32'h40, 32'h12345678, 4'hF, 3'b001, 0, 1, rr);
        chk("oor_b_resp", rr, 2'b10);
        axi_read(32'h40, 3'b001, rd, rr);
        chk("oor_r_resp", rr, 2'b10);
        chk("oor_r_data", rd, 32'h0);
        chk_regs("oor_regs");

        // B backpressure with a second write parked in the holding registers.
        b_ready_i = 0;
        aw_addr_i = 32'h0C; aw_prot_i = 3'b001; w_data_i = 32'h12345678; w_strb_i = 4'hF;
        aw_valid_i = 1; w_valid_i = 1;
        tick();
        aw_valid_i = 0; w_valid_i = 0;
        tick();
        mdl_wr(32'h0C, 32'h12345678, 4'hF, 3'b001, er);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                aw_addr_i = 32'h10; w_data_i = 32'hCAFEF00D;
                aw_valid_i = 1; w_valid_i = 1;
            end
            chk("bp_b_valid", b_valid_o, 1);
            chk("bp_b_resp", b_resp_o, 2'b00);
            tick();
            aw_valid_i = 0; w_valid_i = 0;
        end
        chk("bp_aw_held", aw_ready_o, 0);
        chk("bp_w_held", w_ready_o, 0);
        chk("bp_reg4_old", regs_o[159:128], 32'h0);
        b_ready_i = 1;
        tick();
        chk("bp_b_cleared", b_valid_o, 0);
        tick();
        mdl_wr(32'h10, 32'hCAFEF00D, 4'hF, 3'b001, er);
        chk("bp_second_b", b_valid_o, 1);
        chk("bp_reg4_new", regs_o[159:128], 32'hCAFEF00D);
        tick();

        // Read handshake on the same edge as a commit to reg2 returns the old value.
        axi_write(32'h08, 32'h5, 4'hF, 3'b001, 0, 0, rr);
        mdl_wr(32'h08, 32'h5, 4'hF, 3'b001, er);
        aw_addr_i = 32'h08; aw_prot_i = 3'b001; w_data_i = 32'h9; w_strb_i = 4'hF;
        aw_valid_i = 1; w_valid_i = 1;
        tick();
        aw_valid_i = 0; w_valid_i = 0;
        ar_addr_i = 32'h08; ar_prot_i = 3'b001; ar_valid_i = 1;
        chk("same_ar_ready", ar_ready_o, 1);
        tick();
        ar_valid_i = 0;
        chk("same_r_valid", r_valid_o, 1);
        chk("same_r_old", r_data_o, 32'h5);
        chk("same_b_valid", b_valid_o, 1);
        tick();
        mdl_wr(32'h08, 32'h9, 4'hF, 3'b001, er);
        axi_read(32'h08, 3'b001, rd, rr);
        chk("same_r_new", rd, 32'h9);

`ifdef AXI_LITE_REG_SLAVE_PROT_EN
        axi_write(32'h08, 32'h77, 4'hF, 3'b000, 0, 0, rr);
        chk("prot_w_resp", rr, 2'b10);
        axi_read(32'h08, 3'b001, rd, rr);
        chk("prot_reg2_kept", rd, 32'h9);
        axi_read(32'h08, 3'b000, rd, rr);
        chk("prot_r_resp", rr, 2'b10);
        chk("prot_r_data", rd, 32'h0);
`endif

        for (int i = 0; i < 80; i++) begin
            addr = 32'($urandom_range(0, 79));
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            prot = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(addr, data, strb, prot, $urandom_range(0, 2), $urandom_range(0, 2), rr);
                mdl_wr(addr, data, strb, prot, er);
                chk("rnd_b_resp", rr, er);
            end else begin
                axi_read(addr, prot, rd, rr);
                mdl_rd(addr, prot, ed, er);
                chk("rnd_r_resp", rr, er);
                chk("rnd_r_data", rd, ed);
            end
        end
        chk_regs("rnd_regs");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
